// File: rtl/switch_debouncer.sv
// Switch debouncer: two-flop synchronizer feeding a four-state stability FSM
// that emits a clean level, one-cycle edge ticks and a saturating bounce count.
module switch_debouncer #(
    parameter int STABLE_CYCLES = 1000000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sw,
    output logic       db_level,
    output logic       rise_tick,
    output logic       fall_tick,
    output logic [7:0] bounce_cnt
);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync1_r;
    logic             sw_s;
    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             bounce_inc_s;
    logic [7:0]       bounce_next_s;
    logic             level_next_s;
    logic             rise_next_s;
    logic             fall_next_s;

    // Two-flop synchronizer for the raw switch input
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sw_s    <= 1'b0;
        end else begin
            sync1_r <= sw;
            sw_s    <= sync1_r;
        end
    end

    // Next-state, window counter and bounce-event decode
    always_comb begin
        state_next_s = ZERO;
        cnt_next_s   = cnt_r;
        bounce_inc_s = 1'b0;
        case (state_r)
            ZERO: begin
                if (sw_s) begin
                    state_next_s = WAIT1;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    state_next_s = ZERO;
                end
            end
            WAIT1: begin
                if (!sw_s) begin
                    state_next_s = ZERO;
                    bounce_inc_s = 1'b1;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ONE;
                end else begin
                    state_next_s = WAIT1;
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            ONE: begin
                if (!sw_s) begin
                    state_next_s = WAIT0;
                    cnt_next_s   = CNT_LOAD;
                end else begin
                    state_next_s = ONE;
                end
            end
            WAIT0: begin
                if (sw_s) begin
                    state_next_s = ONE;
                    bounce_inc_s = 1'b1;
                end else if (cnt_r == CNT_ZERO) begin
                    state_next_s = ZERO;
                end else begin
                    state_next_s = WAIT0;
                    cnt_next_s   = cnt_r - CNT_ONE;
                end
            end
            default: begin
                state_next_s = ZERO;
                cnt_next_s   = cnt_r;
                bounce_inc_s = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so outputs change on the same edge as the state
    always_comb begin
        level_next_s = (state_next_s == ONE) || (state_next_s == WAIT0);
        rise_next_s  = (state_r == WAIT1) && (state_next_s == ONE);
        fall_next_s  = (state_r == WAIT0) && (state_next_s == ZERO);
        if (bounce_inc_s && (bounce_cnt != 8'hFF)) begin
            bounce_next_s = bounce_cnt + 8'd1;
        end else begin
            bounce_next_s = bounce_cnt;
        end
    end

    // FSM, counter and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= ZERO;
            cnt_r      <= CNT_ZERO;
            db_level   <= 1'b0;
            rise_tick  <= 1'b0;
            fall_tick  <= 1'b0;
            bounce_cnt <= 8'd0;
        end else begin
            state_r    <= state_next_s;
            cnt_r      <= cnt_next_s;
            db_level   <= level_next_s;
            rise_tick  <= rise_next_s;
            fall_tick  <= fall_next_s;
            bounce_cnt <= bounce_next_s;
        end
    end

endmodule
